// File: rtl/dma_engineer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dma_engineer_arbiter
// Description : Round-robin arbiter sharing one DMA engine between N_REQ
//               requesters. Latches the winner's start address and length,
//               forwards them to the engine, and steers the ack / data-enable
//               / end-of-packet strobes back to the owner only. The data bus
//               is broadcast to every requester.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_engineer_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 27,
  parameter int DW     = 512,
  parameter int ID_W   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ*ADDR_W-1:0] start_addr_i,
  input  logic [N_REQ*ADDR_W-1:0] length_i,
  output logic [N_REQ-1:0]        ack_o,
  output logic [DW-1:0]           dout_o,
  output logic [N_REQ-1:0]        dout_en_o,
  output logic [N_REQ-1:0]        dout_eop_o,
  output logic                    m_req,
  input  logic                    m_ack,
  output logic [ADDR_W-1:0]       m_start_addr,
  output logic [ADDR_W-1:0]       m_length,
  input  logic [DW-1:0]           m_dout,
  input  logic                    m_dout_en,
  input  logic                    m_dout_eop,
  output logic [ID_W-1:0]         grant_id,
  output logic                    busy,
  output logic                    stray_beat
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_XFER = 2'd2;

  logic [1:0]       state;
  logic [ID_W-1:0]  rr_ptr;

  logic [ID_W-1:0]  winner;
  logic             any_req;
  logic [ID_W:0]    cand_sum;
  logic [ID_W-1:0]  cand;
  logic [ID_W-1:0]  next_ptr;

  logic             last_beat;
  logic             req_acked;
  logic             route_beat;
  logic             stray_now;
  logic [N_REQ-1:0] owner_mask;

  // Search for the first pending request starting at the RR pointer, wrapping.
  always_comb begin
    winner   = '0;
    any_req  = 1'b0;
    cand_sum = '0;
    cand     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand_sum = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (cand_sum >= (ID_W+1)'(N_REQ)) begin
        cand_sum = cand_sum - (ID_W+1)'(N_REQ);
      end
      cand = cand_sum[ID_W-1:0];
      if (!any_req && req_i[cand]) begin
        winner  = cand;
        any_req = 1'b1;
      end
    end
  end

  // Strobe steering: a beat is owned in XFER, or in REQ only when the ack
  // and the final beat land in the same cycle; anything else is stray.
  always_comb begin
    last_beat  = m_dout_en & m_dout_eop;
    req_acked  = (state == ST_REQ) && m_ack;
    route_beat = m_dout_en && ((state == ST_XFER) || (req_acked && m_dout_eop));
    stray_now  = m_dout_en && ((state == ST_IDLE) || ((state == ST_REQ) && !m_ack));
    owner_mask = {{(N_REQ-1){1'b0}}, 1'b1} << grant_id;
    next_ptr   = (grant_id == ID_W'(N_REQ-1)) ? '0 : grant_id + 1'b1;
    ack_o      = req_acked ? owner_mask : '0;
    dout_en_o  = route_beat ? owner_mask : '0;
    dout_eop_o = (route_beat && m_dout_eop) ? owner_mask : '0;
    dout_o     = m_dout;
    busy       = (state != ST_IDLE);
  end

  // Arbitration FSM, latched transfer descriptor, RR pointer and stray flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      rr_ptr       <= '0;
      m_req        <= 1'b0;
      m_start_addr <= '0;
      m_length     <= '0;
      grant_id     <= '0;
      stray_beat   <= 1'b0;
    end else begin
      if (stray_now) begin
        stray_beat <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            state        <= ST_REQ;
            grant_id     <= winner;
            m_start_addr <= start_addr_i[winner*ADDR_W +: ADDR_W];
            m_length     <= length_i[winner*ADDR_W +: ADDR_W];
            m_req        <= 1'b1;
          end
        end
        ST_REQ: begin
          if (m_ack) begin
            m_req <= 1'b0;
            if (last_beat) begin
              state  <= ST_IDLE;
              rr_ptr <= next_ptr;
            end else begin
              state <= ST_XFER;
            end
          end
        end
        ST_XFER: begin
          if (last_beat) begin
            state  <= ST_IDLE;
            rr_ptr <= next_ptr;
          end
        end
        default: begin
          state <= ST_IDLE;
          m_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dma_engineer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_engineer_arbiter
// Description : Scoreboard bench for dma_engineer_arbiter. Stimulus pushes the
//               expected grant / ack / beat events; a monitor pops and
//               compares whenever the DUT presents one.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_engineer_arbiter;

  localparam int N  = 4;
  localparam int AW = 27;
  localparam int DW = 512;
  localparam int IW = 2;

  localparam int K_GRANT = 0;
  localparam int K_ACK   = 1;
  localparam int K_BEAT  = 2;

  typedef struct {
    int           kind;
    logic [N-1:0] vec;
    logic [N-1:0] eop;
    logic [IW-1:0] gid;
    logic [AW-1:0] addr;
    logic [AW-1:0] len;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_i = '0;
  logic [N*AW-1:0] start_addr_i = '0;
  logic [N*AW-1:0] length_i = '0;
  logic [N-1:0]   ack_o;
  logic [DW-1:0]  dout_o;
  logic [N-1:0]   dout_en_o;
  logic [N-1:0]   dout_eop_o;
  logic           m_req;
  logic           m_ack = 1'b0;
  logic [AW-1:0]  m_start_addr;
  logic [AW-1:0]  m_length;
  logic [DW-1:0]  m_dout = '0;
  logic           m_dout_en = 1'b0;
  logic           m_dout_eop = 1'b0;
  logic [IW-1:0]  grant_id;
  logic           busy;
  logic           stray_beat;

  logic [AW-1:0]  addr_tab [N];
  logic [AW-1:0]  len_tab  [N];
  logic           prev_req = 1'b0;

  dma_engineer_arbiter #(
    .N_REQ(N), .ADDR_W(AW), .DW(DW), .ID_W(IW)
  ) dut (
    .clk(clk), .rst(rst), .req_i(req_i),
    .start_addr_i(start_addr_i), .length_i(length_i),
    .ack_o(ack_o), .dout_o(dout_o), .dout_en_o(dout_en_o), .dout_eop_o(dout_eop_o),
    .m_req(m_req), .m_ack(m_ack), .m_start_addr(m_start_addr), .m_length(m_length),
    .m_dout(m_dout), .m_dout_en(m_dout_en), .m_dout_eop(m_dout_eop),
    .grant_id(grant_id), .busy(busy), .stray_beat(stray_beat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int n);
    logic [31:0] w;
    w = 32'hA5A5_0000 ^ 32'(n);
    return {16{w}};
  endfunction

  task automatic push_grant(input int gid);
    exp_t e;
    e.kind = K_GRANT; e.vec = '0; e.eop = '0; e.gid = IW'(gid);
    e.addr = addr_tab[gid]; e.len = len_tab[gid]; e.data = '0;
    exp_q.push_back(e);
  endtask

  task automatic push_ack(input int owner);
    exp_t e;
    e.kind = K_ACK; e.vec = '0; e.vec[owner] = 1'b1; e.eop = '0; e.gid = '0;
    e.addr = '0; e.len = '0; e.data = '0;
    exp_q.push_back(e);
  endtask

  task automatic push_beat(input int owner, input bit last, input logic [DW-1:0] d);
    exp_t e;
    e.kind = K_BEAT; e.vec = '0; e.vec[owner] = 1'b1;
    e.eop = last ? e.vec : '0; e.gid = '0; e.addr = '0; e.len = '0; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input int kind);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_output kind=%0d actual=present required=none", kind);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != kind) begin
      failures++;
      $display("FAIL event_order actual_kind=%0d required_kind=%0d", kind, e.kind);
      return;
    end
    case (kind)
      K_GRANT: begin
        chk("grant_id", grant_id, e.gid);
        chk("m_start_addr", m_start_addr, e.addr);
        chk("m_length", m_length, e.len);
      end
      K_ACK: chk("ack_o", ack_o, e.vec);
      default: begin
        chk("dout_en_o", dout_en_o, e.vec);
        chk("dout_eop_o", dout_eop_o, e.eop);
        chk("dout_o", dout_o, e.data);
      end
    endcase
  endtask

  // Monitor: compare every presented grant, ack and beat against the queue.
  initial begin
    forever begin
      @(negedge clk);
      if (m_req && !prev_req) pop_check(K_GRANT);
      if (|ack_o) pop_check(K_ACK);
      if ((|dout_en_o) || (|dout_eop_o)) pop_check(K_BEAT);
      prev_req = m_req;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic drive_tabs();
    for (int k = 0; k < N; k++) begin
      start_addr_i[k*AW +: AW] = addr_tab[k];
      length_i[k*AW +: AW]     = len_tab[k];
    end
  endtask

  task automatic run_beats(input int owner, input int n, input int tag);
    for (int b = 0; b < n; b++) begin
      step();
      m_dout_en  = 1'b1;
      m_dout_eop = (b == n-1);
      m_dout     = pat(tag + b);
      push_beat(owner, (b == n-1), pat(tag + b));
    end
    step();
    m_dout_en  = 1'b0;
    m_dout_eop = 1'b0;
  endtask

  // Entered at the start of an idle cycle; returns at the start of the idle
  // cycle that follows the last beat.
  task automatic xfer(input int owner, input logic [N-1:0] reqv, input int n,
                      input int tag, input bit drop);
    req_i = reqv;
    push_grant(owner);
    at_neg();
    chk("gap_busy", busy, 0);
    chk("gap_m_req", m_req, 0);
    step();
    m_ack = 1'b1;
    push_ack(owner);
    if (drop) req_i = '0;
    at_neg();
    chk("grant_m_req", m_req, 1);
    chk("grant_busy", busy, 1);
    step();
    m_ack = 1'b0;
    at_neg();
    chk("ack_clears_m_req", m_req, 0);
    run_beats(owner, n, tag);
    req_i = '0;
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      addr_tab[k] = AW'(1000 + 16*k);
      len_tab[k]  = AW'(3);
    end
    drive_tabs();

    // Reset state
    repeat (3) step();
    rst = 1'b0;
    at_neg();
    chk("rst_busy", busy, 0);
    chk("rst_m_req", m_req, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_stray", stray_beat, 0);
    chk("rst_m_start_addr", m_start_addr, 0);
    chk("rst_m_length", m_length, 0);
    chk("rst_ack_o", ack_o, 0);

    // Single request, requester drops req after the grant
    addr_tab[2] = AW'(52);
    len_tab[2]  = AW'(100);
    drive_tabs();
    step();
    xfer(2, 4'b0100, 100, 1000, 1'b1);
    at_neg();
    chk("single_done_busy", busy, 0);

    // Round robin with all requests held, from a fresh pointer
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    for (int k = 0; k < N; k++) begin
      addr_tab[k] = AW'(1000 + 16*k);
      len_tab[k]  = AW'(3);
    end
    drive_tabs();
    for (int t = 0; t < 8; t++) xfer(t % N, 4'b1111, 3, 2000 + 10*t, 1'b0);

    // Pointer wrap and skip: after grant 3, requests 0 and 2
    xfer(0, 4'b0101, 3, 3000, 1'b0);
    xfer(2, 4'b0101, 3, 3100, 1'b0);

    // Simultaneous ack and last beat, owner 1
    req_i = 4'b0010;
    push_grant(1);
    step();
    req_i = '0;
    m_ack = 1'b1; m_dout_en = 1'b1; m_dout_eop = 1'b1; m_dout = pat(5000);
    push_ack(1);
    push_beat(1, 1'b1, pat(5000));
    step();
    m_ack = 1'b0; m_dout_en = 1'b0; m_dout_eop = 1'b0;
    at_neg();
    chk("simul_idle_busy", busy, 0);
    chk("simul_m_req", m_req, 0);
    step();
    xfer(2, 4'b1111, 1, 5100, 1'b0);

    // Stray beat while idle
    m_dout_en = 1'b1; m_dout = pat(6000);
    at_neg();
    chk("stray_dropped", dout_en_o, 0);
    step();
    m_dout_en = 1'b0;
    at_neg();
    chk("stray_set", stray_beat, 1);
    step();
    at_neg();
    chk("stray_sticky", stray_beat, 1);

    // Descriptor hold while inputs change during the transfer
    addr_tab[1] = AW'(52);
    len_tab[1]  = AW'(4);
    drive_tabs();
    step();
    req_i = 4'b0010;
    push_grant(1);
    step();
    m_ack = 1'b1; req_i = '0;
    push_ack(1);
    step();
    m_ack = 1'b0;
    start_addr_i[1*AW +: AW] = AW'(200);
    length_i[1*AW +: AW]     = AW'(77);
    run_beats(1, 4, 7000);
    at_neg();
    chk("hold_addr", m_start_addr, 52);
    chk("hold_len", m_length, 4);
    chk("hold_gid", grant_id, 1);

    // Reset in the middle of a 10-beat transfer
    addr_tab[2] = AW'(300);
    len_tab[2]  = AW'(10);
    drive_tabs();
    step();
    req_i = 4'b0100;
    push_grant(2);
    step();
    req_i = '0; m_ack = 1'b1;
    push_ack(2);
    step();
    m_ack = 1'b0;
    for (int b = 0; b < 5; b++) begin
      step();
      m_dout_en = 1'b1; m_dout_eop = 1'b0; m_dout = pat(8000 + b);
      push_beat(2, 1'b0, pat(8000 + b));
    end
    step();
    m_dout_en = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    at_neg();
    chk("midrst_busy", busy, 0);
    chk("midrst_m_req", m_req, 0);
    chk("midrst_grant_id", grant_id, 0);
    chk("midrst_stray", stray_beat, 0);
    for (int b = 0; b < 5; b++) begin
      step();
      m_dout_en = 1'b1; m_dout_eop = (b == 4); m_dout = pat(8100 + b);
      at_neg();
      chk("midrst_beat_dropped", dout_en_o, 0);
    end
    step();
    m_dout_en = 1'b0; m_dout_eop = 1'b0;
    at_neg();
    chk("midrst_stray_set", stray_beat, 1);
    step();
    xfer(1, 4'b0010, 2, 9000, 1'b0);
    at_neg();
    chk("final_busy", busy, 0);

    step();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_expectations actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
